snn_output_spike_counter: RTL



---
 rtl/snn_pkg.sv | 20 ++
 rtl/snn_argmax_scan.sv | 80 ++++++++
 rtl/snn_output_spike_counter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN output stage: controller states,
// index-width derivation and a saturating increment.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Callers pass the all-ones value of their own counter width as max_v.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/snn_argmax_scan.sv
// Sequential argmax: walks one neuron per cycle after start_i and pulses
// done_o in the last scan cycle together with the final best index/count.
module snn_argmax_scan
  import snn_pkg::*;
#(
  parameter int N  = 2,
  parameter int CW = 5,
  parameter int IW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          abort_i,
  input  logic          start_i,
  input  logic [CW-1:0] cnt_i,
  output logic [IW-1:0] idx_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [IW-1:0] best_idx_o,
  output logic [CW-1:0] best_cnt_o
);

  logic          busy_q, busy_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [CW-1:0] best_cnt_q, best_cnt_d;
  logic          better_s, last_s;
  logic [IW-1:0] cand_idx_s;
  logic [CW-1:0] cand_cnt_s;

  // Strict compare so that ties keep the lowest index already held.
  always_comb begin
    better_s   = (cnt_i > best_cnt_q);
    last_s     = (idx_q == IW'(N - 1));
    cand_idx_s = better_s ? idx_q : best_idx_q;
    cand_cnt_s = better_s ? cnt_i : best_cnt_q;
    busy_d     = busy_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    if (abort_i) begin
      busy_d     = 1'b0;
      idx_d      = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
    end else if (start_i) begin
      busy_d     = 1'b1;
      idx_d      = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
    end else if (busy_q) begin
      busy_d     = !last_s;
      idx_d      = last_s ? idx_q : idx_q + IW'(1);
      best_idx_d = cand_idx_s;
      best_cnt_d = cand_cnt_s;
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
    end
  end

  assign idx_o      = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = busy_q && last_s;
  assign best_idx_o = cand_idx_s;
  assign best_cnt_o = cand_cnt_s;

endmodule

// File: rtl/snn_output_spike_counter.sv
// Per-neuron saturating spike counters for the final SNN layer, with an
// argmax scan on sim_done and registered readback for the register file.
module snn_output_spike_counter
  import snn_pkg::*;
#(
  parameter int NUM_OUTPUTS        = 2,
  parameter int COUNT_WIDTH        = 5,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int IDX_W              = idx_width(NUM_OUTPUTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          spike_valid,
  input  logic [NUM_OUTPUTS-1:0]        spikes,
  input  logic                          sim_done,
  input  logic [IDX_W-1:0]              rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          busy,
  output logic                          result_valid,
  output logic [IDX_W-1:0]              winner,
  output logic [COUNT_WIDTH-1:0]        winner_count,
  output logic [COUNT_WIDTH-1:0]        timesteps,
  output logic                          overrun
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  state_e                          state_q, state_d;
  logic [COUNT_WIDTH-1:0]          cnt_q [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0]          cnt_d [NUM_OUTPUTS];
  logic [COUNT_WIDTH-1:0]          ts_q, ts_d;
  logic                            ov_q, ov_d;
  logic                            rv_q, rv_d;
  logic [IDX_W-1:0]                win_q, win_d;
  logic [COUNT_WIDTH-1:0]          wc_q, wc_d;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rd_q, rd_d;

  logic                            accept_s, start_s;
  logic                            scan_busy_s, scan_done_s;
  logic [IDX_W-1:0]                scan_idx_s, scan_best_idx_s;
  logic [COUNT_WIDTH-1:0]          scan_cnt_s, scan_best_cnt_s, rd_sel_s;

  assign accept_s = spike_valid && !clear && (state_q != ST_SCAN);
  assign start_s  = sim_done && !clear && (state_q != ST_SCAN);

  snn_argmax_scan #(
    .N  (NUM_OUTPUTS),
    .CW (COUNT_WIDTH),
    .IW (IDX_W)
  ) u_scan (
    .clk_i      (clk),
    .rst_i      (rst),
    .abort_i    (clear),
    .start_i    (start_s),
    .cnt_i      (scan_cnt_s),
    .idx_o      (scan_idx_s),
    .busy_o     (scan_busy_s),
    .done_o     (scan_done_s),
    .best_idx_o (scan_best_idx_s),
    .best_cnt_o (scan_best_cnt_s)
  );

  // Out-of-range addresses match no entry and fall through to zero.
  always_comb begin
    scan_cnt_s = '0;
    rd_sel_s   = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      scan_cnt_s = (scan_idx_s == IDX_W'(i)) ? cnt_q[i] : scan_cnt_s;
      rd_sel_s   = (rd_addr == IDX_W'(i)) ? cnt_q[i] : rd_sel_s;
    end
    rd_d = C_S_AXI_DATA_WIDTH'(rd_sel_s);
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: state_d = start_s ? ST_SCAN : state_q;
        ST_SCAN:          state_d = scan_done_s ? ST_DONE : ST_SCAN;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ts_d = ts_q;
    for (int i = 0; i < NUM_OUTPUTS; i++) cnt_d[i] = cnt_q[i];
    if (clear) begin
      ts_d = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_d[i] = '0;
    end else if (accept_s) begin
      ts_d = COUNT_WIDTH'(sat_inc(32'(ts_q), 32'(CNT_MAX)));
      for (int i = 0; i < NUM_OUTPUTS; i++)
        cnt_d[i] = spikes[i] ? COUNT_WIDTH'(sat_inc(32'(cnt_q[i]), 32'(CNT_MAX))) : cnt_q[i];
    end else begin
      ts_d = ts_q;
    end
  end

  // Result is only reloaded by a finished scan; later spikes leave it alone.
  always_comb begin
    rv_d  = rv_q;
    win_d = win_q;
    wc_d  = wc_q;
    ov_d  = ov_q;
    if (clear) begin
      rv_d  = 1'b0;
      win_d = '0;
      wc_d  = '0;
      ov_d  = 1'b0;
    end else begin
      ov_d = ov_q | (spike_valid && (state_q == ST_SCAN));
      if (start_s) begin
        rv_d = 1'b0;
      end else if (scan_done_s) begin
        rv_d  = 1'b1;
        win_d = scan_best_idx_s;
        wc_d  = scan_best_cnt_s;
      end else begin
        rv_d = rv_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      ov_q    <= 1'b0;
      rv_q    <= 1'b0;
      win_q   <= '0;
      wc_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      ov_q    <= ov_d;
      rv_q    <= rv_d;
      win_q   <= win_d;
      wc_q    <= wc_d;
      rd_q    <= rd_d;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_data      = rd_q;
  assign busy         = scan_busy_s;
  assign result_valid = rv_q;
  assign winner       = win_q;
  assign winner_count = wc_q;
  assign timesteps    = ts_q;
  assign overrun      = ov_q;

endmodule
